// File: rtl/lwb_pkg.sv
// Shared types, load-width encodings and the access legality rule for the load/writeback unit.
package lwb_pkg;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   localparam int MEM_TIMEOUT_DEFAULT = 255;

   function automatic logic load_access_err(input logic [2:0] f3, input logic [1:0] addr_lo);
      case (f3)
         F3_LB, F3_LBU: return 1'b0;
         F3_LH, F3_LHU: return addr_lo[0];
         F3_LW:         return addr_lo != 2'b00;
         default:       return 1'b1;
      endcase
   endfunction
endpackage

// File: rtl/load_writeback_unit_if.sv
// Execute-side, data-memory read and register-file write-port signals of the load/writeback unit.
interface lwb_if #(
   parameter int XLEN = 32,
   parameter int REGW = 5
);
   logic            ex_valid;
   logic            ex_ready;
   logic            ex_is_load;
   logic            ex_wb_en;
   logic [REGW-1:0] ex_rd;
   logic [2:0]      ex_funct3;
   logic [XLEN-1:0] ex_alu_res;
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [XLEN-1:0] mem_req_addr;
   logic            mem_rsp_valid;
   logic [XLEN-1:0] mem_rsp_data;
   logic [REGW-1:0] wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            wb_we;
   logic            err_access;
   logic            err_timeout;
   logic            busy;

   modport master (
      input  ex_valid, ex_is_load, ex_wb_en, ex_rd, ex_funct3, ex_alu_res,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
      output ex_ready, mem_req_valid, mem_req_addr,
      output wb_rd, wb_data, wb_we, err_access, err_timeout, busy
   );

   modport slave (
      output ex_valid, ex_is_load, ex_wb_en, ex_rd, ex_funct3, ex_alu_res,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data,
      input  ex_ready, mem_req_valid, mem_req_addr,
      input  wb_rd, wb_data, wb_we, err_access, err_timeout, busy
   );
endinterface

// File: rtl/load_writeback_unit_extender.sv
// Combinational lane select and sign/zero extension of a loaded word.
// Latency 0; no flow control.
module load_extender
   import lwb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] value
);
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      case (addr_lo)
         2'd0:    lane_b = word[7:0];
         2'd1:    lane_b = word[15:8];
         2'd2:    lane_b = word[23:16];
         default: lane_b = word[31:24];
      endcase
      lane_h = addr_lo[1] ? word[31:16] : word[15:0];

      case (funct3)
         F3_LB:   value = {{(XLEN-8){lane_b[7]}}, lane_b};
         F3_LH:   value = {{(XLEN-16){lane_h[15]}}, lane_h};
         F3_LBU:  value = {{(XLEN-8){1'b0}}, lane_b};
         F3_LHU:  value = {{(XLEN-16){1'b0}}, lane_h};
         default: value = word;
      endcase
   end
endmodule

// File: rtl/load_writeback_unit.sv
// Register-file writer: ALU results written 1 cycle after accept, loads >= 3 cycles via a memory read.
// Backpressure: ex_ready low while a load is outstanding; the read request is held until mem_req_ready.
module load_writeback_unit
   import lwb_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int REGW        = 5,
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic  clk,
   input  logic  rst,
   lwb_if.master bus
);
   localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

   state_t          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [REGW-1:0] rd_q, rd_d;
   logic [2:0]      f3_q, f3_d;
   logic            wben_q, wben_d;
   logic            we_q, we_d;
   logic            acc_q, acc_d;
   logic            tmo_q, tmo_d;
   logic [REGW-1:0] wb_rd_q, wb_rd_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;
   logic [XLEN-1:0] ext_value;

   load_extender #(.XLEN(XLEN)) u_ext (
      .word    (bus.mem_rsp_data),
      .addr_lo (addr_q[1:0]),
      .funct3  (f3_q),
      .value   (ext_value)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         rd_q      <= '0;
         f3_q      <= '0;
         wben_q    <= 1'b0;
         we_q      <= 1'b0;
         acc_q     <= 1'b0;
         tmo_q     <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         rd_q      <= rd_d;
         f3_q      <= f3_d;
         wben_q    <= wben_d;
         we_q      <= we_d;
         acc_q     <= acc_d;
         tmo_q     <= tmo_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
      end
   end

   // wb_rd/wb_data only move on a real write so the port holds its last value otherwise.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      rd_d      = rd_q;
      f3_d      = f3_q;
      wben_d    = wben_q;
      we_d      = 1'b0;
      acc_d     = 1'b0;
      tmo_d     = 1'b0;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      case (state_q)
         IDLE: begin
            if (bus.ex_valid) begin
               if (!bus.ex_is_load) begin
                  we_d = bus.ex_wb_en && (bus.ex_rd != '0);
                  if (we_d) begin
                     wb_rd_d   = bus.ex_rd;
                     wb_data_d = bus.ex_alu_res;
                  end
               end else begin
                  addr_d = bus.ex_alu_res;
                  rd_d   = bus.ex_rd;
                  f3_d   = bus.ex_funct3;
                  wben_d = bus.ex_wb_en;
                  if (load_access_err(bus.ex_funct3, bus.ex_alu_res[1:0])) begin
                     acc_d = 1'b1;
                  end else begin
                     state_d = REQ;
                  end
               end
            end
         end
         REQ: begin
            if (bus.mem_req_ready) begin
               state_d = WAIT;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            // A response in the final timeout cycle still counts as a response.
            if (bus.mem_rsp_valid) begin
               we_d = wben_q && (rd_q != '0);
               if (we_d) begin
                  wb_rd_d   = rd_q;
                  wb_data_d = ext_value;
               end
               state_d = WB;
            end else if (cnt_q == TMO_LIMIT) begin
               tmo_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.ex_ready      = (state_q == IDLE);
   assign bus.busy          = (state_q != IDLE);
   assign bus.mem_req_valid = (state_q == REQ);
   assign bus.mem_req_addr  = {addr_q[XLEN-1:2], 2'b00};
   assign bus.wb_we         = we_q;
   assign bus.wb_rd         = wb_rd_q;
   assign bus.wb_data       = wb_data_q;
   assign bus.err_access    = acc_q;
   assign bus.err_timeout   = tmo_q;
endmodule
